// File: rtl/fetch_unit_pkg.sv
// Shared constants and IF/ID payload type for the WISC fetch stage.
package fetch_unit_pkg;

   localparam int unsigned N = 16;

   localparam logic [N-1:0] RESET_PC  = 16'h0000;
   localparam logic [N-1:0] NOP_INSTR = 16'h0800;

   // One fetched instruction together with its address and link value.
   typedef struct packed {
      logic [N-1:0] instr;
      logic [N-1:0] pc;
      logic [N-1:0] pc_plus2;
   } ifid_t;

   // Instructions are halfword aligned; bit 0 of any target is dropped.
   function automatic logic [N-1:0] align_pc(input logic [N-1:0] addr);
      return addr & {{(N-1){1'b1}}, 1'b0};
   endfunction

endpackage

// File: rtl/cla_16b.sv
// 16-bit adder: 4-bit groups with lookahead between groups, ripple inside a group.
// Result is modulo 2^16; no carry out is produced.
module cla_16b (
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   input  logic        cin_i,
   output logic [15:0] sum_o
);

   logic [14:0] g;
   logic [15:0] p;
   logic [15:0] c;
   logic [2:0]  grp_g;
   logic [2:0]  grp_p;
   logic [3:0]  gc;

   assign g = a_i[14:0] & b_i[14:0];
   assign p = a_i ^ b_i;

   // Group generate/propagate, inter-group lookahead, then per-bit carries.
   always_comb begin
      grp_g = '0;
      grp_p = '0;
      gc    = '0;
      c     = '0;
      for (int k = 0; k < 3; k++) begin
         grp_g[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
         grp_p[k] = &p[4*k +: 4];
      end
      gc[0] = cin_i;
      for (int k = 0; k < 3; k++) begin
         gc[k+1] = grp_g[k] | (grp_p[k] & gc[k]);
      end
      for (int i = 0; i < 16; i++) begin
         if ((i % 4) == 0) c[i] = gc[i/4];
         else              c[i] = g[i-1] | (p[i-1] & c[i-1]);
      end
   end

   assign sum_o = p ^ c;

endmodule

// File: rtl/fetch_unit.sv
// WISC instruction fetch: PC, multi-cycle imem handshake, skid buffer, IF/ID register.
module fetch_unit
   import fetch_unit_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         redirect_en,
   input  logic [N-1:0] redirect_pc,
   input  logic         id_stall,
   input  logic         halt,
   output logic         imem_rd,
   output logic [N-1:0] imem_addr,
   input  logic [N-1:0] imem_data,
   input  logic         imem_done,
   output logic [N-1:0] if_instr,
   output logic [N-1:0] if_pc,
   output logic [N-1:0] if_pc_plus2,
   output logic         if_valid,
   output logic         halted,
   output logic         err
);

   typedef enum logic [2:0] {
      S_REQ    = 3'd0,
      S_WAIT   = 3'd1,
      S_HOLD   = 3'd2,
      S_DRAIN  = 3'd3,
      S_HALTED = 3'd4
   } state_e;

   state_e       state_q, state_d;
   logic [N-1:0] pc_q, pc_d;
   logic [N-1:0] addr_q, addr_d;
   ifid_t        ifid_q, ifid_d;
   logic         valid_q, valid_d;
   ifid_t        skid_q, skid_d;
   logic         halt_pend_q, halt_pend_d;
   logic         halted_q, halted_d;
   logic         err_q, err_d;

   logic [N-1:0] pc_plus2;
   logic         redirect_ok;
   logic         halt_ok;
   logic         miss_in_flight;

   cla_16b u_pc_add (
      .a_i   (pc_q),
      .b_i   (16'h0002),
      .cin_i (1'b0),
      .sum_o (pc_plus2)
   );

   assign redirect_ok    = redirect_en && (state_q != S_HALTED);
   assign halt_ok        = halt && !redirect_en && (state_q != S_HALTED);
   assign miss_in_flight = (state_q == S_WAIT) && !imem_done;

   // State and pipeline registers, synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_REQ;
         pc_q        <= RESET_PC;
         addr_q      <= RESET_PC;
         ifid_q      <= {NOP_INSTR, N'(0), N'(0)};
         valid_q     <= 1'b0;
         skid_q      <= '0;
         halt_pend_q <= 1'b0;
         halted_q    <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         addr_q      <= addr_d;
         ifid_q      <= ifid_d;
         valid_q     <= valid_d;
         skid_q      <= skid_d;
         halt_pend_q <= halt_pend_d;
         halted_q    <= halted_d;
         err_q       <= err_d;
      end
   end

   // Next-state, PC, IF/ID and skid update.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      addr_d      = addr_q;
      ifid_d      = ifid_q;
      valid_d     = valid_q;
      skid_d      = skid_q;
      halt_pend_d = halt_pend_q;
      halted_d    = halted_q;
      err_d       = err_q;

      // Remember the address a read was issued at, for draining after a redirect.
      if ((state_q == S_REQ) || (state_q == S_WAIT)) addr_d = pc_q;

      // Decode consumed the instruction and nothing new arrives: bubble.
      if (!id_stall) begin
         valid_d      = 1'b0;
         ifid_d.instr = NOP_INSTR;
      end

      if (redirect_ok || halt_ok) begin
         valid_d      = 1'b0;
         ifid_d.instr = NOP_INSTR;
      end

      if (redirect_ok) begin
         pc_d  = align_pc(redirect_pc);
         err_d = err_q | redirect_pc[0];
      end

      case (state_q)
         S_REQ, S_WAIT: begin
            if (redirect_ok) begin
               state_d = miss_in_flight ? S_DRAIN : S_REQ;
            end else if (halt_ok) begin
               if (miss_in_flight) begin
                  state_d     = S_DRAIN;
                  halt_pend_d = 1'b1;
               end else begin
                  state_d  = S_HALTED;
                  halted_d = 1'b1;
               end
            end else if (imem_done) begin
               pc_d = pc_plus2;
               if (!id_stall || !valid_q) begin
                  ifid_d  = {imem_data, pc_q, pc_plus2};
                  valid_d = 1'b1;
                  state_d = S_REQ;
               end else begin
                  skid_d  = {imem_data, pc_q, pc_plus2};
                  state_d = S_HOLD;
               end
            end else begin
               state_d = S_WAIT;
            end
         end
         S_HOLD: begin
            if (redirect_ok) begin
               state_d = S_REQ;
            end else if (halt_ok) begin
               state_d  = S_HALTED;
               halted_d = 1'b1;
            end else if (!id_stall) begin
               ifid_d  = skid_q;
               valid_d = 1'b1;
               state_d = S_REQ;
            end
         end
         S_DRAIN: begin
            // A later redirect proves any pending halt was wrong-path.
            if (redirect_ok)  halt_pend_d = 1'b0;
            else if (halt_ok) halt_pend_d = 1'b1;
            if (imem_done) begin
               if (halt_pend_d) begin
                  state_d  = S_HALTED;
                  halted_d = 1'b1;
               end else begin
                  state_d = S_REQ;
               end
               halt_pend_d = 1'b0;
            end
         end
         S_HALTED: begin
         end
         default: begin
            state_d = S_REQ;
         end
      endcase
   end

   // Memory request: in DRAIN the stale address must stay on the bus.
   assign imem_rd   = !rst && ((state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_DRAIN));
   assign imem_addr = (state_q == S_DRAIN) ? addr_q : pc_q;

   assign if_instr    = ifid_q.instr;
   assign if_pc       = ifid_q.pc;
   assign if_pc_plus2 = ifid_q.pc_plus2;
   assign if_valid    = valid_q;
   assign halted      = halted_q;
   assign err         = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: hits, misses, stalls, redirects, halt and reset.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   logic         clk;
   logic         rst;
   logic         redirect_en;
   logic [N-1:0] redirect_pc;
   logic         id_stall;
   logic         halt;
   logic         imem_rd;
   logic [N-1:0] imem_addr;
   logic [N-1:0] imem_data;
   logic         imem_done;
   logic [N-1:0] if_instr;
   logic [N-1:0] if_pc;
   logic [N-1:0] if_pc_plus2;
   logic         if_valid;
   logic         halted;
   logic         err;

   int n_checks;
   int n_fail;

   fetch_unit dut (
      .clk         (clk),
      .rst         (rst),
      .redirect_en (redirect_en),
      .redirect_pc (redirect_pc),
      .id_stall    (id_stall),
      .halt        (halt),
      .imem_rd     (imem_rd),
      .imem_addr   (imem_addr),
      .imem_data   (imem_data),
      .imem_done   (imem_done),
      .if_instr    (if_instr),
      .if_pc       (if_pc),
      .if_pc_plus2 (if_pc_plus2),
      .if_valid    (if_valid),
      .halted      (halted),
      .err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Check the IF/ID register holds a real instruction.
   task automatic check_ifid(input string tag, input logic [N-1:0] ins, input logic [N-1:0] pc);
      check_eq({tag, ".valid"}, 32'(if_valid), 32'd1);
      check_eq({tag, ".instr"}, 32'(if_instr), 32'(ins));
      check_eq({tag, ".pc"}, 32'(if_pc), 32'(pc));
      check_eq({tag, ".pc2"}, 32'(if_pc_plus2), 32'(N'(pc + 16'd2)));
   endtask

   task automatic check_bubble(input string tag);
      check_eq({tag, ".valid"}, 32'(if_valid), 32'd0);
      check_eq({tag, ".instr"}, 32'(if_instr), 32'(NOP_INSTR));
   endtask

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      rst         = 1'b1;
      redirect_en = 1'b0;
      redirect_pc = '0;
      id_stall    = 1'b0;
      halt        = 1'b0;
      imem_data   = '0;
      imem_done   = 1'b0;

      // Reset state
      tick();
      tick();
      check_eq("rst.rd", 32'(imem_rd), 32'd0);
      check_bubble("rst");
      check_eq("rst.pc", 32'(if_pc), 32'd0);
      check_eq("rst.pc2", 32'(if_pc_plus2), 32'd0);
      check_eq("rst.halted", 32'(halted), 32'd0);
      check_eq("rst.err", 32'(err), 32'd0);
      rst = 1'b0;
      #1;
      check_eq("req0.rd", 32'(imem_rd), 32'd1);
      check_eq("req0.addr", 32'(imem_addr), 32'h0000);

      // 1: hit every cycle, one instruction per cycle
      for (int k = 0; k < 4; k++) begin
         imem_done = 1'b1;
         imem_data = 16'hA000 + 16'(2 * k);
         tick();
         check_ifid("hit", 16'hA000 + 16'(2 * k), 16'(2 * k));
         check_eq("hit.addr", 32'(imem_addr), 32'(2 * k + 2));
      end
      imem_done = 1'b0;

      // Move to 0x0010 for the miss test
      redirect_en = 1'b1;
      redirect_pc = 16'h0010;
      tick();
      redirect_en = 1'b0;
      check_bubble("redir10");
      check_eq("redir10.addr", 32'(imem_addr), 32'h0010);

      // 2: three-cycle miss at 0x0010
      tick();
      check_eq("miss.c2.rd", 32'(imem_rd), 32'd1);
      check_eq("miss.c2.addr", 32'(imem_addr), 32'h0010);
      tick();
      check_eq("miss.c3.rd", 32'(imem_rd), 32'd1);
      check_eq("miss.c3.addr", 32'(imem_addr), 32'h0010);
      check_eq("miss.c3.valid", 32'(if_valid), 32'd0);
      imem_done = 1'b1;
      imem_data = 16'h1234;
      tick();
      check_ifid("miss", 16'h1234, 16'h0010);

      // 3: decode stalls four cycles while memory keeps hitting
      id_stall  = 1'b1;
      imem_data = 16'h3012;
      tick();
      check_ifid("stall.c1", 16'h1234, 16'h0010);
      check_eq("stall.c1.rd", 32'(imem_rd), 32'd0);
      imem_data = 16'hDEAD;
      for (int k = 0; k < 3; k++) begin
         tick();
         check_ifid("stall.hold", 16'h1234, 16'h0010);
         check_eq("stall.hold.rd", 32'(imem_rd), 32'd0);
      end
      id_stall  = 1'b0;
      imem_done = 1'b0;
      tick();
      check_ifid("skid", 16'h3012, 16'h0012);
      check_eq("skid.addr", 32'(imem_addr), 32'h0014);
      imem_done = 1'b1;
      imem_data = 16'h3014;
      tick();
      check_ifid("after_skid", 16'h3014, 16'h0014);
      imem_done = 1'b0;

      // 4a: redirect while a miss is outstanding
      tick();
      check_bubble("wait16");
      redirect_en = 1'b1;
      redirect_pc = 16'h0100;
      tick();
      redirect_en = 1'b0;
      check_eq("drain.rd", 32'(imem_rd), 32'd1);
      check_eq("drain.addr", 32'(imem_addr), 32'h0016);
      check_bubble("drain");
      tick();
      check_eq("drain2.addr", 32'(imem_addr), 32'h0016);
      imem_done = 1'b1;
      imem_data = 16'hBAD0;
      tick();
      check_bubble("drained");
      check_eq("drained.rd", 32'(imem_rd), 32'd1);
      check_eq("drained.addr", 32'(imem_addr), 32'h0100);
      imem_data = 16'h5100;
      tick();
      check_ifid("tgt100", 16'h5100, 16'h0100);

      // 4b: redirect in the same cycle the miss completes
      imem_done = 1'b0;
      tick();
      redirect_en = 1'b1;
      redirect_pc = 16'h0200;
      imem_done   = 1'b1;
      imem_data   = 16'hBAD1;
      tick();
      redirect_en = 1'b0;
      imem_done   = 1'b0;
      check_bubble("samecyc");
      check_eq("samecyc.addr", 32'(imem_addr), 32'h0200);
      check_eq("samecyc.rd", 32'(imem_rd), 32'd1);

      // 5: misaligned target sets sticky err; PC wraps at 0xFFFE
      check_eq("err.before", 32'(err), 32'd0);
      redirect_en = 1'b1;
      redirect_pc = 16'h0101;
      tick();
      redirect_en = 1'b0;
      check_eq("err.set", 32'(err), 32'd1);
      check_eq("err.addr", 32'(imem_addr), 32'h0100);
      imem_done = 1'b1;
      imem_data = 16'h6100;
      tick();
      check_ifid("err.fetch", 16'h6100, 16'h0100);
      imem_done   = 1'b0;
      redirect_en = 1'b1;
      redirect_pc = 16'hFFFE;
      tick();
      redirect_en = 1'b0;
      check_eq("err.sticky", 32'(err), 32'd1);
      check_eq("wrap.addr0", 32'(imem_addr), 32'hFFFE);
      imem_done = 1'b1;
      imem_data = 16'h7FFE;
      tick();
      imem_done = 1'b0;
      check_eq("wrap.pc", 32'(if_pc), 32'hFFFE);
      check_eq("wrap.pc2", 32'(if_pc_plus2), 32'h0000);
      check_eq("wrap.addr", 32'(imem_addr), 32'h0000);

      // 6: halt during a miss
      tick();
      halt = 1'b1;
      tick();
      halt = 1'b0;
      check_eq("halt.drain.rd", 32'(imem_rd), 32'd1);
      check_eq("halt.drain.halted", 32'(halted), 32'd0);
      check_bubble("halt.drain");
      imem_done = 1'b1;
      imem_data = 16'hBAD2;
      tick();
      check_eq("halted", 32'(halted), 32'd1);
      check_eq("halted.rd", 32'(imem_rd), 32'd0);
      check_bubble("halted");
      redirect_en = 1'b1;
      redirect_pc = 16'h0041;
      for (int k = 0; k < 3; k++) begin
         tick();
         check_eq("halted.stay", 32'(halted), 32'd1);
         check_eq("halted.stay.rd", 32'(imem_rd), 32'd0);
         check_eq("halted.noerr", 32'(err), 32'd1);
         check_eq("halted.valid", 32'(if_valid), 32'd0);
      end
      redirect_en = 1'b0;
      imem_done   = 1'b0;

      // Reset out of HALTED, then reset in the middle of a miss
      rst = 1'b1;
      tick();
      check_eq("rst2.rd", 32'(imem_rd), 32'd0);
      check_eq("rst2.halted", 32'(halted), 32'd0);
      check_eq("rst2.err", 32'(err), 32'd0);
      rst = 1'b0;
      #1;
      check_eq("rst2.rel.rd", 32'(imem_rd), 32'd1);
      check_eq("rst2.rel.addr", 32'(imem_addr), 32'h0000);
      tick();
      rst = 1'b1;
      tick();
      check_eq("rst3.rd", 32'(imem_rd), 32'd0);
      check_bubble("rst3");
      rst = 1'b0;
      #1;
      check_eq("rst3.rel.rd", 32'(imem_rd), 32'd1);
      check_eq("rst3.rel.addr", 32'(imem_addr), 32'h0000);
      imem_done = 1'b1;
      imem_data = 16'h9000;
      tick();
      imem_done = 1'b0;
      check_ifid("restart", 16'h9000, 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
